// File: rtl/user_wb_mailbox.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : user_wb_mailbox                                        |
// | Description : Wishbone classic slave with two 32-bit FIFOs (mgmt to  |
// |               user and user to mgmt), status, sticky error flags and |
// |               a registered level interrupt.                          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module user_wb_mailbox #(
   parameter logic [31:0] BASE_ADR   = 32'h3000_0000,
   parameter int          DEPTH_LOG2 = 2
) (
   input  logic        core_clk,
   input  logic        core_rstn,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [3:0]  wb_sel_i,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   output logic        wb_ack_o,
   output logic [31:0] wb_dat_o,
   output logic [31:0] usr_rx_data,
   output logic        usr_rx_valid,
   input  logic        usr_rx_ready,
   input  logic [31:0] usr_tx_data,
   input  logic        usr_tx_valid,
   output logic        usr_tx_ready,
   output logic        irq_o
);

   localparam int         c_DEPTH      = 1 << DEPTH_LOG2;
   localparam int         c_PW         = DEPTH_LOG2 + 1;
   localparam logic [1:0] c_REG_DATA   = 2'd0;
   localparam logic [1:0] c_REG_STATUS = 2'd1;
   localparam logic [1:0] c_REG_IRQEN  = 2'd2;

   logic [31:0]     r_m2u_mem [c_DEPTH];
   logic [31:0]     r_u2m_mem [c_DEPTH];
   logic [c_PW-1:0] r_m2u_wptr, r_m2u_rptr, r_u2m_wptr, r_u2m_rptr;
   logic            r_ovf, r_unf, r_ack, r_irq;
   logic [2:0]      r_irq_en;
   logic [31:0]     r_dat;

   logic            w_hit, w_accept, w_wr_data, w_rd_data;
   logic [1:0]      w_reg;
   logic            w_m2u_empty, w_m2u_full, w_u2m_empty, w_u2m_full;
   logic [c_PW-1:0] w_m2u_cnt, w_u2m_cnt;
   logic            w_m2u_push, w_m2u_pop, w_u2m_push, w_u2m_pop;
   logic            w_ovf_set, w_unf_set, w_stat_wr, w_en_wr;
   logic [31:0]     w_status, w_rd_mux;
   logic            w_irq_cond;
   logic            w_unused;

   // Bus decode: a miss never qualifies, and the ack cycle blocks re-accept.
   assign w_hit     = (wb_adr_i[31:4] == BASE_ADR[31:4]);
   assign w_accept  = wb_cyc_i & wb_stb_i & w_hit & ~r_ack;
   assign w_reg     = wb_adr_i[3:2];
   assign w_wr_data = w_accept &  wb_we_i & (w_reg == c_REG_DATA);
   assign w_rd_data = w_accept & ~wb_we_i & (w_reg == c_REG_DATA);
   assign w_stat_wr = w_accept &  wb_we_i & (w_reg == c_REG_STATUS) & wb_sel_i[0];
   assign w_en_wr   = w_accept &  wb_we_i & (w_reg == c_REG_IRQEN)  & wb_sel_i[0];

   // Pointer-difference FIFO flags; the extra MSB separates full from empty.
   assign w_m2u_empty = (r_m2u_wptr == r_m2u_rptr);
   assign w_m2u_full  = (r_m2u_wptr[c_PW-1] != r_m2u_rptr[c_PW-1]) &&
                        (r_m2u_wptr[c_PW-2:0] == r_m2u_rptr[c_PW-2:0]);
   assign w_u2m_empty = (r_u2m_wptr == r_u2m_rptr);
   assign w_u2m_full  = (r_u2m_wptr[c_PW-1] != r_u2m_rptr[c_PW-1]) &&
                        (r_u2m_wptr[c_PW-2:0] == r_u2m_rptr[c_PW-2:0]);
   assign w_m2u_cnt   = r_m2u_wptr - r_m2u_rptr;
   assign w_u2m_cnt   = r_u2m_wptr - r_u2m_rptr;

   // Flags are pre-edge, so a bus push to a full M2U drops even if the user pops.
   assign w_m2u_push = w_wr_data & ~w_m2u_full;
   assign w_ovf_set  = w_wr_data &  w_m2u_full;
   assign w_m2u_pop  = ~w_m2u_empty & usr_rx_ready;
   assign w_u2m_push = usr_tx_valid & ~w_u2m_full;
   assign w_u2m_pop  = w_rd_data & ~w_u2m_empty;
   assign w_unf_set  = w_rd_data &  w_u2m_empty;

   assign w_status = {12'd0, 4'(w_u2m_cnt), 4'd0, 4'(w_m2u_cnt), 2'd0,
                      r_unf, r_ovf, w_u2m_full, w_u2m_empty, w_m2u_full, w_m2u_empty};

   assign w_irq_cond = |(r_irq_en & {r_ovf | r_unf, w_m2u_empty, ~w_u2m_empty});

   // Read-data select for the addressed register.
   always_comb begin
      w_rd_mux = 32'd0;
      case (w_reg)
         c_REG_DATA:   w_rd_mux = w_u2m_empty ? 32'd0 : r_u2m_mem[r_u2m_rptr[c_PW-2:0]];
         c_REG_STATUS: w_rd_mux = w_status;
         c_REG_IRQEN:  w_rd_mux = {29'd0, r_irq_en};
         default:      w_rd_mux = 32'd0;
      endcase
   end

   // FIFO storage needs no reset: outputs are gated by the empty flags.
   always_ff @(posedge core_clk) begin
      if (w_m2u_push) r_m2u_mem[r_m2u_wptr[c_PW-2:0]] <= wb_dat_i;
      if (w_u2m_push) r_u2m_mem[r_u2m_wptr[c_PW-2:0]] <= usr_tx_data;
   end

   // FIFO pointers advance on their own push/pop strobes.
   always_ff @(posedge core_clk or negedge core_rstn) begin
      if (!core_rstn) begin
         r_m2u_wptr <= '0;
         r_m2u_rptr <= '0;
         r_u2m_wptr <= '0;
         r_u2m_rptr <= '0;
      end else begin
         if (w_m2u_push) r_m2u_wptr <= r_m2u_wptr + 1'b1;
         if (w_m2u_pop)  r_m2u_rptr <= r_m2u_rptr + 1'b1;
         if (w_u2m_push) r_u2m_wptr <= r_u2m_wptr + 1'b1;
         if (w_u2m_pop)  r_u2m_rptr <= r_u2m_rptr + 1'b1;
      end
   end

   // Sticky error flags (a new event wins over a W1C) and the IRQ enable mask.
   always_ff @(posedge core_clk or negedge core_rstn) begin
      if (!core_rstn) begin
         r_ovf    <= 1'b0;
         r_unf    <= 1'b0;
         r_irq_en <= 3'd0;
      end else begin
         if (w_ovf_set)                   r_ovf <= 1'b1;
         else if (w_stat_wr & wb_dat_i[4]) r_ovf <= 1'b0;
         if (w_unf_set)                   r_unf <= 1'b1;
         else if (w_stat_wr & wb_dat_i[5]) r_unf <= 1'b0;
         if (w_en_wr)                     r_irq_en <= wb_dat_i[2:0];
      end
   end

   // Single-cycle ack with registered read data, zero outside read acks.
   always_ff @(posedge core_clk or negedge core_rstn) begin
      if (!core_rstn) begin
         r_ack <= 1'b0;
         r_dat <= 32'd0;
         r_irq <= 1'b0;
      end else begin
         r_ack <= w_accept;
         r_dat <= (w_accept & ~wb_we_i) ? w_rd_mux : 32'd0;
         r_irq <= w_irq_cond;
      end
   end

   assign wb_ack_o     = r_ack;
   assign wb_dat_o     = r_dat;
   assign irq_o        = r_irq;
   assign usr_rx_valid = ~w_m2u_empty;
   assign usr_rx_data  = w_m2u_empty ? 32'd0 : r_m2u_mem[r_m2u_rptr[c_PW-2:0]];
   assign usr_tx_ready = ~w_u2m_full;

   // Address bits [1:0] and upper byte lanes carry no meaning here.
   assign w_unused = ^{wb_adr_i[1:0], wb_sel_i[3:1]};

endmodule
`default_nettype wire

// File: tb/tb_user_wb_mailbox.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_user_wb_mailbox                                     |
// | Description : Self-checking bench for user_wb_mailbox: directed      |
// |               scenarios plus a random sequence against a queue model.|
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_user_wb_mailbox;

   localparam logic [31:0] c_BASE  = 32'h3000_0000;
   localparam int          c_DEPTH = 4;

   logic        core_clk = 1'b0;
   logic        core_rstn = 1'b0;
   logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
   logic [3:0]  wb_sel_i = 4'h0;
   logic [31:0] wb_adr_i = 32'd0, wb_dat_i = 32'd0;
   logic        wb_ack_o;
   logic [31:0] wb_dat_o;
   logic [31:0] usr_rx_data;
   logic        usr_rx_valid;
   logic        usr_rx_ready = 1'b0;
   logic [31:0] usr_tx_data = 32'd0;
   logic        usr_tx_valid = 1'b0;
   logic        usr_tx_ready;
   logic        irq_o;

   int tests = 0;
   int fails = 0;

   // Reference model: two bounded queues, two sticky flags, an enable mask.
   logic [31:0] m2u_q[$];
   logic [31:0] u2m_q[$];
   logic        m_ovf = 1'b0, m_unf = 1'b0;
   logic [2:0]  m_en = 3'd0;

   logic        ack_irq, ack_rxv, push_irq;
   logic [31:0] rd_val;

   user_wb_mailbox #(.BASE_ADR(c_BASE), .DEPTH_LOG2(2)) dut (
      .core_clk(core_clk), .core_rstn(core_rstn),
      .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
      .wb_sel_i(wb_sel_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
      .wb_ack_o(wb_ack_o), .wb_dat_o(wb_dat_o),
      .usr_rx_data(usr_rx_data), .usr_rx_valid(usr_rx_valid), .usr_rx_ready(usr_rx_ready),
      .usr_tx_data(usr_tx_data), .usr_tx_valid(usr_tx_valid), .usr_tx_ready(usr_tx_ready),
      .irq_o(irq_o)
   );

   always #5 core_clk = ~core_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_status();
      logic [3:0] mc, uc;
      mc = 4'(m2u_q.size());
      uc = 4'(u2m_q.size());
      return {12'd0, uc, 4'd0, mc, 2'd0, m_unf, m_ovf,
              u2m_q.size() == c_DEPTH, u2m_q.size() == 0,
              m2u_q.size() == c_DEPTH, m2u_q.size() == 0};
   endfunction

   function automatic logic model_irq();
      return (m_en[0] && u2m_q.size() != 0) || (m_en[1] && m2u_q.size() == 0) ||
             (m_en[2] && (m_ovf || m_unf));
   endfunction

   // One bus access: ack expected one cycle after accept, then exactly one idle cycle.
   task automatic bus(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                      input logic [3:0] sel, output logic [31:0] rdat);
      int n;
      wb_adr_i = adr; wb_we_i = we; wb_dat_i = wdat; wb_sel_i = sel;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
      @(posedge core_clk); #1;
      chk("ack_latency", {31'd0, wb_ack_o}, 32'd1);
      n = 0;
      while (!wb_ack_o && n < 8) begin
         @(posedge core_clk); #1;
         n++;
      end
      rdat = wb_dat_o;
      ack_irq = irq_o;
      ack_rxv = usr_rx_valid;
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      @(posedge core_clk); #1;
      chk("ack_one_cycle", {31'd0, wb_ack_o}, 32'd0);
   endtask

   task automatic wb_wr(input logic [1:0] r, input logic [31:0] dat, input logic [3:0] sel);
      logic [31:0] d;
      bus(c_BASE | {28'd0, r, 2'b00}, 1'b1, dat, sel, d);
      chk("write_ack_data", d, 32'd0);
      case (r)
         2'd0: if (m2u_q.size() == c_DEPTH) m_ovf = 1'b1; else m2u_q.push_back(dat);
         2'd1: if (sel[0]) begin
                  if (dat[4]) m_ovf = 1'b0;
                  if (dat[5]) m_unf = 1'b0;
               end
         2'd2: if (sel[0]) m_en = dat[2:0];
         default: ;
      endcase
   endtask

   task automatic wb_rd(input logic [1:0] r, input string tag);
      logic [31:0] exp;
      case (r)
         2'd0: if (u2m_q.size() == 0) begin exp = 32'd0; m_unf = 1'b1; end
               else exp = u2m_q.pop_front();
         2'd1: exp = model_status();
         2'd2: exp = {29'd0, m_en};
         default: exp = 32'd0;
      endcase
      bus(c_BASE | {28'd0, r, 2'b00}, 1'b0, 32'd0, 4'hF, rd_val);
      chk(tag, rd_val, exp);
   endtask

   task automatic usr_push(input logic [31:0] d);
      chk("tx_ready", {31'd0, usr_tx_ready}, {31'd0, u2m_q.size() < c_DEPTH});
      usr_tx_data = d; usr_tx_valid = 1'b1;
      @(posedge core_clk); #1;
      usr_tx_valid = 1'b0;
      push_irq = irq_o;
      if (u2m_q.size() < c_DEPTH) u2m_q.push_back(d);
      @(posedge core_clk); #1;
   endtask

   task automatic usr_pop();
      logic [31:0] h;
      h = (m2u_q.size() != 0) ? m2u_q[0] : 32'd0;
      chk("rx_valid", {31'd0, usr_rx_valid}, {31'd0, m2u_q.size() != 0});
      chk("rx_data", usr_rx_data, h);
      usr_rx_ready = 1'b1;
      @(posedge core_clk); #1;
      usr_rx_ready = 1'b0;
      if (m2u_q.size() != 0) void'(m2u_q.pop_front());
      @(posedge core_clk); #1;
   endtask

   initial begin
      // Reset values.
      #2;
      chk("rst_ack", {31'd0, wb_ack_o}, 32'd0);
      chk("rst_dat", wb_dat_o, 32'd0);
      chk("rst_irq", {31'd0, irq_o}, 32'd0);
      chk("rst_rxv", {31'd0, usr_rx_valid}, 32'd0);
      chk("rst_rxd", usr_rx_data, 32'd0);
      chk("rst_txr", {31'd0, usr_tx_ready}, 32'd1);
      @(posedge core_clk); #1;
      core_rstn = 1'b1;
      @(posedge core_clk); #1;

      // Two DATA writes, first-word fall-through on the user side.
      wb_wr(2'd0, 32'hA5A5_0001, 4'hF);
      chk("rxv_in_ack", {31'd0, ack_rxv}, 32'd1);
      wb_wr(2'd0, 32'hA5A5_0002, 4'hF);
      chk("rx_head", usr_rx_data, 32'hA5A5_0001);
      usr_pop();
      usr_pop();
      chk("rx_drained", {31'd0, usr_rx_valid}, 32'd0);

      // Overflow and W1C.
      for (int i = 0; i < 5; i++) wb_wr(2'd0, 32'hC0DE_0000 + i, 4'hF);
      wb_rd(2'd1, "status_ovf");
      wb_wr(2'd1, 32'h10, 4'hF);
      wb_rd(2'd1, "status_w1c");
      for (int i = 0; i < 4; i++) usr_pop();

      // U2M reads with underflow.
      usr_push(32'h1111_1111);
      usr_push(32'h2222_2222);
      for (int i = 0; i < 3; i++) wb_rd(2'd0, "u2m_read");
      wb_rd(2'd1, "status_unf");
      chk("unf_bit", {31'd0, rd_val[5]}, 32'd1);
      wb_wr(2'd1, 32'h20, 4'hF);

      // Interrupt timing on U2M not-empty.
      wb_wr(2'd2, 32'h1, 4'hF);
      usr_push(32'h3333_3333);
      chk("irq_lag", {31'd0, push_irq}, 32'd0);
      chk("irq_rise", {31'd0, irq_o}, 32'd1);
      wb_rd(2'd0, "irq_pop");
      chk("irq_at_ack", {31'd0, ack_irq}, 32'd1);
      chk("irq_fall", {31'd0, irq_o}, 32'd0);

      // Miss: no ack, no state change.
      for (int w = 0; w < 2; w++) begin
         wb_adr_i = c_BASE + 32'h10; wb_we_i = w[0]; wb_dat_i = 32'hDEAD_BEEF;
         wb_sel_i = 4'hF; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
         for (int i = 0; i < 10; i++) begin
            @(posedge core_clk); #1;
            chk("miss_no_ack", {31'd0, wb_ack_o}, 32'd0);
         end
         wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      end
      wb_rd(2'd1, "miss_status");

      // Bus push to a full M2U while the user pops in the same cycle.
      while (m2u_q.size() < c_DEPTH) wb_wr(2'd0, $urandom, 4'hF);
      wb_adr_i = c_BASE; wb_we_i = 1'b1; wb_dat_i = 32'hFEED_0000; wb_sel_i = 4'hF;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; usr_rx_ready = 1'b1;
      @(posedge core_clk); #1;
      usr_rx_ready = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      chk("simul_ack", {31'd0, wb_ack_o}, 32'd1);
      void'(m2u_q.pop_front());
      m_ovf = 1'b1;
      @(posedge core_clk); #1;
      wb_rd(2'd1, "simul_status");

      // Random operations against the model.
      for (int k = 0; k < 200; k++) begin
         case ($urandom_range(0, 7))
            0, 1: wb_wr(2'd0, $urandom, 4'($urandom));
            2:    wb_rd(2'd0, "rnd_data");
            3:    usr_push($urandom);
            4:    usr_pop();
            5:    wb_rd(2'd1, "rnd_status");
            6:    wb_wr(2'd1, $urandom, 4'($urandom));
            default: begin
               wb_wr(2'($urandom_range(2, 3)), $urandom, 4'($urandom));
               wb_rd(2'd2, "rnd_irqen");
            end
         endcase
         chk("rnd_irq", {31'd0, irq_o}, {31'd0, model_irq()});
      end

      // Asynchronous reset in the middle of an access.
      while (m2u_q.size() != 0) usr_pop();
      while (u2m_q.size() != 0) wb_rd(2'd0, "drain");
      for (int i = 0; i < 3; i++) wb_wr(2'd0, 32'hB000_0000 + i, 4'hF);
      wb_wr(2'd2, 32'h7, 4'hF);
      wb_adr_i = c_BASE; wb_we_i = 1'b1; wb_dat_i = 32'h5555_5555; wb_sel_i = 4'hF;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
      #3 core_rstn = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge core_clk); #1;
         chk("rst_no_ack", {31'd0, wb_ack_o}, 32'd0);
      end
      chk("rst_rxv2", {31'd0, usr_rx_valid}, 32'd0);
      chk("rst_txr2", {31'd0, usr_tx_ready}, 32'd1);
      chk("rst_irq2", {31'd0, irq_o}, 32'd0);
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      core_rstn = 1'b1;
      m2u_q.delete(); u2m_q.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_en = 3'd0;
      @(posedge core_clk); #1;
      chk("post_rst_no_ack", {31'd0, wb_ack_o}, 32'd0);
      wb_rd(2'd1, "post_rst_status");
      wb_rd(2'd2, "post_rst_irqen");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
